// File: rtl/wireframe_scanout.sv
// wireframe_scanout: reader side of the 1-bit wireframe frame buffer.
// On start, reads every pixel in raster order, optionally clears each location
// after it has been read, and streams the pixels out with sof/eol/eof markers.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, clear_en                  frame request, clear-after-read select
//   busy, done                       frame in progress, one-cycle completion pulse
//   mem_rd_en/addr, mem_rd_data      frame-buffer read port (1-cycle latency)
//   mem_wr_en/addr/data              frame-buffer clear write port
//   px_valid/ready/data/sof/eol/eof  pixel stream with markers
module wireframe_scanout #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned HEIGHT    = 3,
  parameter int unsigned ADDR_SIZE = 8,
  parameter logic        CLEAR_VAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear_en,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_SIZE-1:0] mem_rd_addr,
  input  logic                 mem_rd_data,
  output logic                 mem_wr_en,
  output logic [ADDR_SIZE-1:0] mem_wr_addr,
  output logic                 mem_wr_data,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic                 px_data,
  output logic                 px_sof,
  output logic                 px_eol,
  output logic                 px_eof
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(NPIX - 1);
  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(WIDTH - 1);
  localparam int unsigned E_EOF = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [COL_W-1:0]     r_col;
  logic                 r_clear;
  logic                 r_p1;        // read issued last cycle, data on mem_rd_data now
  logic [2:0]           r_p1_mark;   // {sof, eol, eof} of that read
  logic [3:0]           r_head;      // FIFO entries: {data, sof, eol, eof}
  logic [3:0]           r_tail;
  logic [1:0]           r_cnt;
  logic                 w_pop;
  logic                 w_credit;
  logic [2:0]           w_mark;
  logic [3:0]           w_entry;

  assign w_pop   = px_valid & px_ready;
  // Occupancy + in-flight - pop < 2; the read strobe is decoded this cycle so
  // the credit can count a pop happening right now, which sustains 1 px/clk.
  assign w_credit  = (3'(r_cnt) + 3'(r_p1)) < (3'd2 + 3'(w_pop));
  assign mem_rd_en = (r_state == S_READ) && w_credit;
  assign mem_rd_addr = r_addr;
  assign w_mark  = {r_addr == '0, r_col == LAST_COL, r_addr == LAST_ADDR};
  assign w_entry = {mem_rd_data, r_p1_mark};

  assign px_valid = (r_cnt != 2'd0);
  assign {px_data, px_sof, px_eol, px_eof} = r_head;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  if (mem_rd_en && (r_addr == LAST_ADDR)) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && r_head[E_EOF]) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, address/column counters, read pipeline, clear writes, output FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      r_addr      <= '0;
      r_col       <= '0;
      r_clear     <= 1'b0;
      r_p1        <= 1'b0;
      r_p1_mark   <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_cnt       <= 2'd0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next != S_IDLE);
      done    <= (w_next == S_DONE);

      if ((r_state == S_IDLE) && start) begin
        r_addr  <= '0;
        r_col   <= '0;
        r_clear <= clear_en;
      end else if (mem_rd_en) begin
        // Address parks on the last pixel rather than wrapping
        if (r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_SIZE'(1);
        r_col <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
      end

      r_p1        <= mem_rd_en;
      r_p1_mark   <= w_mark;
      // Clear write lands in the cycle the read data is on the bus
      mem_wr_en   <= mem_rd_en && r_clear;
      mem_wr_addr <= r_addr;
      mem_wr_data <= (mem_rd_en && r_clear) ? CLEAR_VAL : 1'b0;

      case ({r_p1, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= w_entry;
          else               r_tail <= w_entry;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= (r_cnt == 2'd2) ? r_tail : 4'd0;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
            r_tail <= w_entry;
          end else begin
            r_head <= w_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
